// File: rtl/compare_sched.sv
// compare_sched: two-requester round-robin front end for a shared compare unit.
// One compare is in flight at a time. The opcode and operands are latched on
// acceptance, and the shared unit is driven only from those latches. The unit's
// result is captured one cycle later and held until the consumer takes it.

module compare_sched #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [4:0] req0_opcode,
  input  logic [4:0] req1_opcode,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  output logic [4:0] cmp_opcode,
  output logic [2:0] cmp_r1,
  output logic [2:0] cmp_r2,
  input  logic [2:0] cmp_rd,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [2:0] rsp_result,
  output logic       rsp_err,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [4:0] OP_LT  = 5'b01011;
  localparam logic [4:0] OP_GT  = 5'b01100;
  localparam logic [4:0] OP_EQ  = 5'b01101;
  localparam logic [4:0] OP_GTE = 5'b01110;
  localparam logic [4:0] OP_LTE = 5'b01111;
  localparam logic [4:0] OP_NE  = 5'b10000;

  logic [1:0] r_state;
  logic       r_prio;
  logic       r_id;
  logic [4:0] r_cmp_opcode;
  logic [2:0] r_cmp_r1;
  logic [2:0] r_cmp_r2;
  logic [2:0] r_result;
  logic       r_err;

  logic       w_accept;
  logic       w_grant_id;
  logic [4:0] w_grant_op;
  logic [2:0] w_grant_a;
  logic [2:0] w_grant_b;
  logic       w_grant_legal;

  // True when the opcode is one of the six compare operations.
  function automatic logic is_cmp_op(input logic [4:0] op);
    logic ok;
    case (op)
      OP_LT, OP_GT, OP_EQ, OP_GTE, OP_LTE, OP_NE: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Arbitration: the priority holder wins a tie; a lone requester always wins.
  always_comb begin
    w_grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_id = r_prio;
    end else if (req1_valid) begin
      w_grant_id = 1'b1;
    end else begin
      w_grant_id = 1'b0;
    end
  end

  // Acceptance happens only in IDLE and never while reset is asserted.
  assign w_accept      = (r_state == S_IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready    = w_accept && !w_grant_id;
  assign req1_ready    = w_accept &&  w_grant_id;
  assign w_grant_op    = w_grant_id ? req1_opcode : req0_opcode;
  assign w_grant_a     = w_grant_id ? req1_a      : req0_a;
  assign w_grant_b     = w_grant_id ? req1_b      : req0_b;
  assign w_grant_legal = is_cmp_op(w_grant_op);

  // Main FSM. An illegal opcode skips ISSUE and leaves the compare-unit latches untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_prio       <= RR_INIT;
      r_id         <= 1'b0;
      r_cmp_opcode <= 5'd0;
      r_cmp_r1     <= 3'd0;
      r_cmp_r2     <= 3'd0;
      r_result     <= 3'd0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id <= w_grant_id;
            if (w_grant_legal) begin
              r_cmp_opcode <= w_grant_op;
              r_cmp_r1     <= w_grant_a;
              r_cmp_r2     <= w_grant_b;
              r_err        <= 1'b0;
              r_state      <= S_ISSUE;
            end else begin
              r_result <= 3'd0;
              r_err    <= 1'b1;
              r_state  <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          r_result <= cmp_rd;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_prio  <= ~r_id;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmp_opcode = r_cmp_opcode;
  assign cmp_r1     = r_cmp_r1;
  assign cmp_r2     = r_cmp_r2;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_err    = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_compare_sched.sv
// Self-checking bench for compare_sched. It models the shared compare unit,
// keeps a priority and compare-port model, and scoreboards the expected responses.

module tb_compare_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0] req0_opcode, req1_opcode, cmp_opcode;
  logic [2:0] req0_a, req0_b, req1_a, req1_b, cmp_r1, cmp_r2, cmp_rd;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [2:0] rsp_result;

  typedef struct packed {
    logic       id;
    logic [2:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Bench-side model state.
  logic       m_prio;
  logic [4:0] m_cop;
  logic [2:0] m_r1, m_r2;

  always #5 clk = ~clk;

  compare_sched #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .cmp_opcode(cmp_opcode), .cmp_r1(cmp_r1), .cmp_r2(cmp_r2), .cmp_rd(cmp_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  // Compare unit model: the top bits expose the operand order, the low bit is the condition.
  function automatic logic [2:0] cmp_fn(input logic [4:0] op, input logic [2:0] r1, input logic [2:0] r2);
    logic c;
    case (op)
      5'b01011: c = (r1 <  r2);
      5'b01100: c = (r1 >  r2);
      5'b01101: c = (r1 == r2);
      5'b01110: c = (r1 >= r2);
      5'b01111: c = (r1 <= r2);
      5'b10000: c = (r1 != r2);
      default:  c = 1'b0;
    endcase
    return {r1[2], r2[0], c};
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (op >= 5'd11) && (op <= 5'd16);
  endfunction

  assign cmp_rd = cmp_fn(cmp_opcode, cmp_r1, cmp_r2);

  // One full transaction. It starts just after a rising edge with the DUT in IDLE.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [4:0] op0, input logic [2:0] a0, input logic [2:0] b0,
                        input logic [4:0] op1, input logic [2:0] a1, input logic [2:0] b1,
                        input int hold, input logic keep);
    logic gid, legal;
    logic [4:0] gop;
    logic [2:0] ga, gb;
    exp_t e, got, first;
    req0_valid = v0; req0_opcode = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_opcode = op1; req1_a = a1; req1_b = b1;
    rsp_ready  = (hold == 0);
    #1;
    gid   = (v0 && v1) ? m_prio : v1;
    gop   = gid ? op1 : op0;
    ga    = gid ? a1 : a0;
    gb    = gid ? b1 : b0;
    legal = is_legal(gop);
    n_checks++;
    if ({req1_ready, req0_ready} !== {gid, ~gid}) begin
      n_errors++;
      $display("FAIL grant: ready1/0=%b%b expected %b%b", req1_ready, req0_ready, gid, ~gid);
    end
    e.id = gid; e.res = legal ? cmp_fn(gop, ga, gb) : 3'd0; e.err = ~legal;
    sb.push_back(e);
    @(posedge clk); #1;
    if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    if (legal) begin m_cop = gop; m_r1 = ga; m_r2 = gb; end
    #1;
    n_checks++;
    if ({req1_ready, req0_ready, busy} !== 3'b001) begin
      n_errors++;
      $display("FAIL busy_no_accept: ready1/0,busy=%b%b%b expected 001", req1_ready, req0_ready, busy);
    end
    n_checks++;
    if ({cmp_opcode, cmp_r1, cmp_r2} !== {m_cop, m_r1, m_r2}) begin
      n_errors++;
      $display("FAIL cmp_ports: got %b/%0d/%0d expected %b/%0d/%0d", cmp_opcode, cmp_r1, cmp_r2, m_cop, m_r1, m_r2);
    end
    if (legal) begin
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL issue_no_rsp: rsp_valid=%b expected 0", rsp_valid);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rsp_latency: rsp_valid=%b expected 1", rsp_valid);
    end
    first = sb.pop_front();
    got.id = rsp_id; got.res = rsp_result; got.err = rsp_err;
    n_checks++;
    if (got !== first) begin
      n_errors++;
      $display("FAIL rsp_fields: id/res/err=%b/%0d/%b expected %b/%0d/%b",
               got.id, got.res, got.err, first.id, first.res, first.err);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      got.id = rsp_id; got.res = rsp_result; got.err = rsp_err;
      n_checks++;
      if ({rsp_valid, got, req1_ready, req0_ready, busy} !== {1'b1, first, 3'b001}) begin
        n_errors++;
        $display("FAIL backpressure_hold: valid=%b id/res/err=%b/%0d/%b ready1/0=%b%b busy=%b expected 1 %b/%0d/%b 00 1",
                 rsp_valid, got.id, got.res, got.err, req1_ready, req0_ready, busy, first.id, first.res, first.err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL handshake_idle: valid,busy=%b%b expected 00", rsp_valid, busy);
    end
    m_prio = ~first.id;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    req0_opcode = 5'b01011; req1_opcode = 5'b01100;
    req0_a = 3'd1; req0_b = 3'd2; req1_a = 3'd3; req1_b = 3'd4;
    @(posedge clk); #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_ready: ready1/0=%b%b expected 00", req1_ready, req0_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    m_prio = 1'b0; m_cop = 5'd0; m_r1 = 3'd0; m_r2 = 3'd0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_err, busy, cmp_opcode, cmp_r1, cmp_r2} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b id=%b res=%0d err=%b busy=%b cmp=%b/%0d/%0d expected all 0",
               rsp_valid, rsp_id, rsp_result, rsp_err, busy, cmp_opcode, cmp_r1, cmp_r2);
    end
  endtask

  task automatic test_contention();
    logic [3:0] order = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m_prio !== order[i]) begin
        n_errors++;
        $display("FAIL contention_order: model priority=%b expected %b at turn %0d", m_prio, order[i], i);
      end
      run_op(1'b1, 1'b1, 5'b01100, 3'd7, 3'd3, 5'b10000, 3'd2, 3'd6, 0, 1'b1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    run_op(1'b1, 1'b0, 5'b01011, 3'd3, 3'd5, 5'd0, 3'd0, 3'd0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(1'b0, 1'b1, 5'd0, 3'd0, 3'd0, 5'b01110, 3'd4, 3'd1, 5, 1'b0);
  endtask

  task automatic test_illegal();
    run_op(1'b0, 1'b1, 5'd0, 3'd0, 3'd0, 5'b00000, 3'd5, 3'd2, 0, 1'b0);
  endtask

  task automatic test_boundaries();
    run_op(1'b1, 1'b0, 5'b01110, 3'd0, 3'd0, 5'd0, 3'd0, 3'd0, 0, 1'b0);
    run_op(1'b0, 1'b1, 5'd0, 3'd0, 3'd0, 5'b01110, 3'd7, 3'd7, 0, 1'b0);
    run_op(1'b1, 1'b0, 5'b01111, 3'd7, 3'd7, 5'd0, 3'd0, 3'd0, 2, 1'b0);
    run_op(1'b0, 1'b1, 5'd0, 3'd0, 3'd0, 5'b01111, 3'd0, 3'd0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    // Leave priority with requester 1 so that the reset visibly restores it.
    run_op(1'b1, 1'b0, 5'b01011, 3'd1, 3'd2, 5'd0, 3'd0, 3'd0, 0, 1'b0);
    req0_valid = 1'b1; req0_opcode = 5'b01101; req0_a = 3'd2; req0_b = 3'd2;
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_issue: busy=%b expected 1", busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_prio = 1'b0; m_cop = 5'd0; m_r1 = 3'd0; m_r2 = 3'd0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_err, busy, cmp_opcode, cmp_r1, cmp_r2} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: valid=%b id=%b res=%0d err=%b busy=%b cmp=%b/%0d/%0d expected all 0",
               rsp_valid, rsp_id, rsp_result, rsp_err, busy, cmp_opcode, cmp_r1, cmp_r2);
    end
    run_op(1'b1, 1'b1, 5'b01011, 3'd1, 3'd2, 5'b01100, 3'd1, 3'd2, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 1'b0, 5'b10000, 3'd6, 3'd1, 5'd0, 3'd0, 3'd0, 0, 1'b1);
    run_op(1'b0, 1'b1, 5'd0, 3'd0, 3'd0, 5'b01101, 3'd5, 3'd5, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_illegal();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sb.size() !== 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/compare_sched.md
COMPARE_SCHED -- requirements
Module: compare_sched

Interface
REQ-001 SHALL have parameter RR_INIT, default 1'b0: requester index holding priority after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n has a compare pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  request n accepted this cycle.
REQ-006 SHALL have ports req0_opcode / req1_opcode  input  5  compare opcode.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  3  operands R1, R2.
REQ-008 SHALL have ports cmp_opcode  output  5, and cmp_r1, cmp_r2  output  3  drive the shared compare unit.
REQ-009 SHALL have port cmp_rd  input  3  combinational result from the shared compare unit.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes the response.
REQ-012 SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-013 SHALL have port rsp_result  output  3  captured compare result.
REQ-014 SHALL have port rsp_err  output  1  opcode was not a compare opcode.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL recognise legal opcodes LT 01011, GT 01100, EQ 01101, GTE 01110, LTE 01111, NE 10000; all others illegal.
REQ-017 SHALL implement FSM states IDLE, ISSUE, RESP; one operation in flight at a time.
REQ-018 IDLE: no valid request -> stay; req_ready low.
REQ-019 IDLE, one valid: assert only that requester's req_ready combinationally in the same cycle; latch opcode, a, b and id on the edge.
REQ-020 IDLE, both valid: grant the requester holding priority; the other's req_ready stays low.
REQ-021 After an accepted legal opcode the FSM SHALL go to ISSUE; after an illegal opcode it SHALL go directly to RESP with rsp_err=1, rsp_result=3'd0.
REQ-022 cmp_opcode/cmp_r1/cmp_r2 SHALL be driven from the latched registers only, never combinationally from request inputs.
REQ-023 ISSUE lasts exactly one cycle; rsp_result SHALL capture cmp_rd on the ISSUE->RESP edge, unchanged in width.
REQ-024 Latency: request accepted at edge N -> rsp_valid high from cycle after edge N+1 (2 cycles); illegal opcode -> 1 cycle.
REQ-025 RESP: rsp_valid, rsp_id, rsp_result, rsp_err SHALL hold stable until rsp_valid & rsp_ready at an edge.
REQ-026 On the RESP handshake edge the FSM SHALL return to IDLE and priority SHALL pass to the requester other than rsp_id.
REQ-027 No request SHALL be accepted in ISSUE or RESP (both req_ready low); back-to-back issue needs one IDLE cycle.
REQ-028 Priority SHALL only change on a RESP handshake; requests withdrawn before acceptance have no effect.
REQ-029 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-030 rst high at an edge SHALL force IDLE from any state, including mid-ISSUE or mid-RESP, discarding the operation.
REQ-031 Reset values: req0_ready=req1_ready=0 while rst high, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0, cmp_opcode=0, cmp_r1=cmp_r2=0, priority=RR_INIT.

Verification
REQ-032 Single legal: req0 LT a=3 b=5, rsp_ready=1 -> req0_ready one cycle, cmp ports 01011/3/5 in ISSUE, rsp_valid 2 cycles after accept, rsp_id=0, rsp_result=cmp_rd value, rsp_err=0.
REQ-033 Contention: both valid every cycle, req0 GT 7,3, req1 NE 2,6, RR_INIT=0 -> grant order 0,1,0,1; each rsp_id alternates.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both req_ready low, busy=1; release -> IDLE next cycle.
REQ-035 Illegal opcode: req1 opcode 00000 -> accepted, no ISSUE, rsp_valid 1 cycle later, rsp_err=1, rsp_result=0, cmp ports unchanged.
REQ-036 Reset mid-op: rst during ISSUE of EQ 2,2 -> next cycle IDLE, rsp_valid=0, all outputs at REQ-031 values, priority=RR_INIT.
REQ-037 Boundaries: operands 0/0 and 7/7 for GTE, LTE -> values pass unmodified to cmp_r1/cmp_r2 and result captured exactly.
